// File: rtl/mul_exec_unit_pkg.sv
// Shared RV64M multiply constants; the decode-side stall detector uses the same encodings.
package mul_exec_unit_pkg;

    localparam int DATA_BITS = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] OPC_MULW  = 7'b0111011;

endpackage

// File: rtl/mul_pp33.sv
// Signed W x W partial-product multiplier; unsigned lo halves arrive zero-padded to W bits.
module mul_pp33 #(
    parameter int W = 33
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    logic signed [2*W-1:0] a_s;
    logic signed [2*W-1:0] b_s;

    assign a_s = {{W{a_i[W-1]}}, a_i};
    assign b_s = {{W{b_i[W-1]}}, b_i};
    assign p_o = a_s * b_s;

endmodule

// File: rtl/mul_exec_unit.sv
// Two-stage RV64M multiplier: partial products registered at issue, summed and selected in stage 2.
module mul_exec_unit
    import mul_exec_unit_pkg::*;
#(
    parameter int DATA_BITS = mul_exec_unit_pkg::DATA_BITS,
    parameter int REG_BITS  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [2:0]           funct3,
    input  logic                 is_word,
    input  logic [DATA_BITS-1:0] rs1_val,
    input  logic [DATA_BITS-1:0] rs2_val,
    input  logic [REG_BITS-1:0]  rd_in,
    input  logic                 flush,
    output logic                 valid_out,
    output logic [DATA_BITS-1:0] result,
    output logic [REG_BITS-1:0]  rd_out,
    output logic                 busy
);

    localparam int EXT = DATA_BITS + 1;
    localparam int LO  = DATA_BITS / 2;
    localparam int HI  = EXT - LO;
    localparam int PPW = 2 * HI;
    localparam int PW  = 2 * DATA_BITS;

    // Handshake: an op is accepted when start=1 and flush=0; valid_out pulses for exactly one
    // cycle on the next cycle. There is no ready: the consumer must take the result that cycle.
    logic           accept;
    logic           rs1_sgn;
    logic           rs2_sgn;
    logic [EXT-1:0] ext1;
    logic [EXT-1:0] ext2;
    logic [HI-1:0]  a_lo, a_hi, b_lo, b_hi;
    logic [PPW-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;

    logic [PPW-1:0]      pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
    logic [2:0]          f3_q;
    logic                word_q;
    logic [REG_BITS-1:0] rd_q;
    logic                valid_q;
    logic [PW-1:0]       prod;

    assign accept  = start & ~flush;
    assign rs1_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign rs2_sgn = (funct3 == F3_MULH);
    assign ext1    = {rs1_sgn & rs1_val[DATA_BITS-1], rs1_val};
    assign ext2    = {rs2_sgn & rs2_val[DATA_BITS-1], rs2_val};

    assign a_lo = {{(HI-LO){1'b0}}, ext1[LO-1:0]};
    assign a_hi = ext1[EXT-1:LO];
    assign b_lo = {{(HI-LO){1'b0}}, ext2[LO-1:0]};
    assign b_hi = ext2[EXT-1:LO];

    mul_pp33 #(.W(HI)) u_pp_ll (.a_i(a_lo), .b_i(b_lo), .p_o(pp_ll_d));
    mul_pp33 #(.W(HI)) u_pp_lh (.a_i(a_lo), .b_i(b_hi), .p_o(pp_lh_d));
    mul_pp33 #(.W(HI)) u_pp_hl (.a_i(a_hi), .b_i(b_lo), .p_o(pp_hl_d));
    mul_pp33 #(.W(HI)) u_pp_hh (.a_i(a_hi), .b_i(b_hi), .p_o(pp_hh_d));

    // Payload loads only on accept, so result/rd_out hold their last values while idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= 1'b0;
            pp_ll_q <= '0;
            pp_lh_q <= '0;
            pp_hl_q <= '0;
            pp_hh_q <= '0;
            f3_q    <= '0;
            word_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                pp_ll_q <= pp_ll_d;
                pp_lh_q <= pp_lh_d;
                pp_hl_q <= pp_hl_d;
                pp_hh_q <= pp_hh_d;
                f3_q    <= funct3;
                word_q  <= is_word;
                rd_q    <= rd_in;
            end
        end
    end

    function automatic logic [PW-1:0] sx(input logic [PPW-1:0] x);
        return {{(PW-PPW){x[PPW-1]}}, x};
    endfunction

    // Sum is kept to 128 bits: the two top bits of the full 130-bit product are never selected.
    assign prod = sx(pp_ll_q)
                + (sx(pp_lh_q) << LO)
                + (sx(pp_hl_q) << LO)
                + (sx(pp_hh_q) << (2 * LO));

    always_comb begin
        result = prod[DATA_BITS-1:0];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[PW-1:DATA_BITS];
            default: begin
                if (word_q) begin
                    result = {{(DATA_BITS-32){prod[31]}}, prod[31:0]};
                end
            end
        endcase
    end

    assign valid_out = valid_q;
    assign busy      = valid_q;
    assign rd_out    = rd_q;

endmodule

// File: doc/mul_exec_unit.md
# mul_exec_unit

Two-stage RV64M multiply execution unit in the EX stage. It consumes the multiply instructions that the decode-side multiply stall detector has already spaced out with a one-cycle bubble. It accepts one MUL/MULH/MULHSU/MULHU/MULW operation per cycle and returns the result exactly one cycle after issue, together with the destination register tag. The one-cycle stall upstream exists to absorb this extra cycle.

## Interface
Parameters:
- `DATA_BITS`, 64: operand and result width (shared global define).
- `REG_BITS`, 5: destination register index width.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue a multiply this cycle.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes are treated as MUL.
- `is_word`  in  1  MULW (opcode 0111011); valid only with funct3 = 000.
- `rs1_val`, `rs2_val`  in  DATA_BITS  operands.
- `rd_in`  in  REG_BITS  destination tag.
- `flush`  in  1  squash the in-flight op and any op issued this cycle.
- `valid_out`  out  1  result valid this cycle.
- `result`  out  DATA_BITS  product selection.
- `rd_out`  out  REG_BITS  tag of the op in `result`.
- `busy`  out  1  op in stage 2 (equals `valid_out`; kept for hazard logic).

## Operation
- Stage 1 (issue cycle N):
  - Extend each operand to 65 bits. `rs1` is sign-extended for MULH and MULHSU. `rs2` is sign-extended for MULH only. Otherwise both are zero-extended.
  - Split each 65-bit operand into lo[31:0] and hi[64:32] (33 bits).
  - Compute four partial products: lo×lo, lo×hi, hi×lo, hi×hi.
  - At the edge ending cycle N, register the partial products, the op select (`funct3`, `is_word`), `rd_in`, and a valid bit.
- Stage 2 (cycle N+1):
  - Sum the registered partials with the correct shifts into a 130-bit signed product P, combinationally.
  - `result` selection:
    - MUL: P[63:0].
    - MULH/MULHSU/MULHU: P[127:64].
    - MULW: sign-extend P[31:0] to 64 bits.
- All arithmetic is two's complement. No overflow detection. Width truncation is exactly as listed above.
- Throughput is 1 op/cycle; back-to-back `start` is legal and pipelines.
- `start` with `flush` in the same cycle: the incoming op is dropped and the stage-2 op is squashed, so `valid_out` is 0 next cycle.
- `flush` alone: the stage-1 valid register clears at the next edge. The current-cycle `valid_out` is unaffected, because the consumer handles squash of its own stage.

## Timing
- Reset values: stage valid 0, `valid_out` 0, `busy` 0, `result` 0, `rd_out` 0, all pipeline registers 0.
- Latency is exactly 1 cycle: `start` at cycle N gives `valid_out` = 1 at cycle N+1. There is no backpressure.
- `valid_out` is a single-cycle pulse per accepted op. Two consecutive starts give two consecutive pulses.
- Reset asserted mid-operation clears all state immediately (asynchronous). No result is produced after reset deasserts.
- When `valid_out` = 0, `result` and `rd_out` are held at their last values (the registers do not load). The verifier checks them only when `valid_out` = 1.
- The stage-2 combinational adder path is the critical path. Only the stage-1 registers sit between the multipliers and the sum.

## Structure
- Shared package/defines: `DATA_BITS`, funct3 encodings (MUL/MULH/MULHSU/MULHU), MULW opcode constant. These are the same constants the stall detector decodes.
- One sub-module, `mul_pp33`: a signed 33×33 partial-product multiplier, instantiated four times (lo operands zero-padded to 33 bits).
- The top-level module holds the extension logic, the pipeline registers, the summation and the result mux.

## Test plan
- Signed MUL: MUL 3 × 0xFFFFFFFFFFFFFFFB (−5) → `result` 0xFFFFFFFFFFFFFFF1 at N+1, `rd_out` = `rd_in`.
- Signed high half: MULH 0x8000000000000000 × 0x8000000000000000 → 0x4000000000000000.
- Unsigned high half: MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE.
- Mixed-sign high half: MULHSU rs1 = 0xFFFFFFFFFFFFFFFF (−1) × rs2 = 0xFFFFFFFFFFFFFFFF (unsigned) → 0xFFFFFFFFFFFFFFFF.
- MULW sign extension: MULW 0x0000000040000000 × 2 → 0xFFFFFFFF80000000.
- Pipelining and squash:
  - Back-to-back MUL 2×3 then MUL 4×5 → `valid_out` high for two consecutive cycles, results 6 then 20.
  - `start` with `flush` → no `valid_out`.
  - `RST` low in the cycle after `start` → `valid_out` 0 and `result` 0 immediately.
